// File: rtl/seg_display_pkg.sv
// Shared constants and the hex-to-segment glyph lookup for the seven-segment debug scanner.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] nibble_to_glyph(input logic [3:0] i_nibble);
        return GLYPH_TABLE[i_nibble];
    endfunction

endpackage

// File: rtl/seg_edge_sync.sv
// Two-flop synchroniser for an asynchronous level plus a registered rising-edge pulse,
// high for the single cycle in which the synchronised level first reads 1.
module seg_edge_sync
    import seg_display_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_pulse;

    // The pulse is formed one stage early so it lines up with the first high synced level.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_pulse <= r_meta & ~r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/seg_display_scanner.sv
// Button-stepped probe channel selector with optional freeze, time-multiplexed onto a
// shared seven-segment bus. Build option: LEADING_ZERO_BLANK_EN blanks leading zero nibbles.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_CH*DATA_W-1:0]   i_ch_data,
    input  logic                       i_next_ch,
    input  logic                       i_freeze,
    output logic [$clog2(NUM_CH)-1:0]  o_ch_sel,
    output logic                       o_frozen,
    output logic [6:0]                 o_seg_out,
    output logic [NUM_DIGITS-1:0]      o_digit_en
);

    localparam int unsigned CH_W     = $clog2(NUM_CH);
    localparam int unsigned DIG_W    = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W    = $clog2(SCAN_DIV);
    localparam int unsigned NUM_NIB  = DATA_W / 4;
    localparam int unsigned NUM_DISP = (NUM_NIB < NUM_DIGITS - 1) ? NUM_NIB : NUM_DIGITS - 1;

    logic              w_step;
    logic              w_freeze_sync;
    logic              w_freeze_rise_unused;
    logic [DATA_W-1:0] w_word;
    logic [3:0]        w_ch_nib;
    logic [6:0]        w_seg;

    logic [CH_W-1:0]       r_ch_sel;
    logic                  r_reload;
    logic                  r_frozen;
    logic [DATA_W-1:0]     r_snapshot;
    logic [PRE_W-1:0]      r_presc;
    logic [DIG_W-1:0]      r_digit;
    logic [6:0]            r_seg_out;
    logic [NUM_DIGITS-1:0] r_digit_en;

    seg_edge_sync u_next_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_next_ch),
        .o_level (),
        .o_pulse (w_step)
    );

    seg_edge_sync u_freeze_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_freeze),
        .o_level (w_freeze_sync),
        .o_pulse (w_freeze_rise_unused)
    );

    assign w_word   = i_ch_data[r_ch_sel*DATA_W +: DATA_W];
    assign w_ch_nib = 4'(r_ch_sel);

    // A step taken while frozen arms r_reload so the new channel is captured exactly once.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ch_sel   <= '0;
            r_reload   <= 1'b0;
            r_frozen   <= 1'b0;
            r_snapshot <= '0;
        end else begin
            r_frozen <= w_freeze_sync;
            r_reload <= w_step;
            if (w_step) begin
                r_ch_sel <= (r_ch_sel == CH_W'(NUM_CH - 1)) ? '0 : r_ch_sel + 1'b1;
            end
            if (!r_frozen || r_reload) begin
                r_snapshot <= w_word;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_digit <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [4*NUM_DISP-1:0] w_disp;
    logic [NUM_DISP-1:0]   w_upper_zero;

    assign w_disp = r_snapshot[4*NUM_DISP-1:0];

    // w_upper_zero[i]: displayed nibble i and every displayed nibble above it are zero.
    always_comb begin
        w_upper_zero = '0;
        for (int unsigned i = 0; i < NUM_DISP; i++) begin
            w_upper_zero[i] = ((w_disp >> (4 * i)) == '0);
        end
    end
`endif

    always_comb begin
        w_seg = SEG_BLANK;
        if (r_digit == DIG_W'(NUM_DIGITS - 1)) begin
            w_seg = nibble_to_glyph(w_ch_nib);
        end else begin
            for (int unsigned i = 0; i < NUM_DISP; i++) begin
                if (r_digit == DIG_W'(i)) begin
                    w_seg = nibble_to_glyph(r_snapshot[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
                    if (i != 0 && w_upper_zero[i]) begin
                        w_seg = SEG_BLANK;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_seg_out  <= SEG_BLANK;
            r_digit_en <= '0;
        end else begin
            r_seg_out  <= w_seg;
            r_digit_en <= NUM_DIGITS'(1) << r_digit;
        end
    end

    assign o_ch_sel   = r_ch_sel;
    assign o_frozen   = r_frozen;
    assign o_seg_out  = r_seg_out;
    assign o_digit_en = r_digit_en;

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Parametrised successor to the board-level display mapping.
- Takes NUM_CH debug probe words (PC, instruction, data result, flags, ...) and selects one with a button-stepped channel pointer, stepping forward and wrapping.
- Optionally freezes the selected word into a snapshot.
- Time-multiplexes the snapshot and channel index onto NUM_DIGITS seven-segment digits through one shared segment bus.
- Sits between the processor core debug outputs and the FPGA pins.

Parameters:
- NUM_CH, 4, number of probe channels; must be ≥2.
- DATA_W, 16, width of each probe word; must be a multiple of 4.
- NUM_DIGITS, 6, physical digits; must be ≥2.
- SCAN_DIV, 50000, clock cycles each digit stays enabled; must be ≥2.

Ports:
- clock  in  1  processor/board clock.
- reset  in  1  asynchronous, active-high reset.
- ch_data  in  NUM_CH*DATA_W  packed probe words; channel k occupies bits [k*DATA_W +: DATA_W].
- next_ch  in  1  asynchronous push-button level, active-high.
- freeze  in  1  asynchronous level, active-high: hold the snapshot.
- ch_sel  out  clog2(NUM_CH)  current channel index.
- frozen  out  1  high while the snapshot is held.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- digit_en  out  NUM_DIGITS  one-hot digit enable, active-high.

Behaviour:
- Reset: asynchronous, active-high; the clock is single-domain.
  - ch_sel=0, frozen=0, snapshot=0.
  - Prescaler=0, digit index=0.
  - seg_out=7'h7F (all off), digit_en=0.
- Input synchronisers: next_ch and freeze each pass through a 2-flop synchroniser. Synchroniser flops reset to 0.
- Channel step:
  - A rising edge of synchronised next_ch increments ch_sel, registered in the cycle after the edge is detected.
  - ch_sel wraps from NUM_CH-1 to 0.
  - A held button gives exactly one step.
- Snapshot:
  - frozen follows synchronised freeze, registered.
  - While frozen=0, the snapshot loads the selected channel word every cycle, so snapshot lags ch_data by 1 cycle.
  - While frozen=1, the snapshot holds.
  - Exception: a channel step while frozen=1 reloads the snapshot once, in the cycle after ch_sel changes, with the new channel's word, then holds again.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances and the prescaler returns to 0.
  - The digit index wraps from NUM_DIGITS-1 to 0.
- Digit content:
  - Digit NUM_DIGITS-1 shows ch_sel as a hex glyph (low 4 bits).
  - Digit i < NUM_DIGITS-1 shows snapshot nibble i when i < DATA_W/4, otherwise blank (7'h7F).
  - Nibbles beyond NUM_DIGITS-1 are not displayed.
- Output stage:
  - seg_out and digit_en are registered from the digit index, snapshot and ch_sel.
  - They update the cycle after any of these changes.
  - digit_en is always exactly one-hot outside reset; there is no blank gap between digits.
  - First cycle after reset release: digit_en=1, seg_out=glyph(0)=7'h40.
- Latency: ch_data to seg_out of the enabled digit is 2 cycles. next_ch pin to ch_sel change is 3 cycles.
- Simultaneous events:
  - Terminal count and a channel step in the same cycle: both take effect.
  - freeze rising in the same cycle as a channel step: the reload rule applies.
  - Reset mid-scan returns everything to the reset values immediately.
- Glyph encoding for 0-F, active-low: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: among data digits i = DATA_W/4-1 down to 1, a digit whose nibble and all higher displayed nibbles are 0 is blanked (7'h7F). Digit 0 is always shown, and the channel digit is unaffected.
- Undefined: all data digits show their hex glyph, including leading zeros.

Decomposition:
- Package seg_display_pkg:
  - SEG_BLANK = 7'h7F.
  - The 16-entry glyph constant table.
  - A nibble-to-glyph function.
- One sub-module, seg_edge_sync: 2-flop synchroniser plus registered rising-edge pulse. It is instantiated for next_ch; freeze uses only its synchronised level output.

Test Plan (bench uses SCAN_DIV=4, NUM_CH=4, DATA_W=16, NUM_DIGITS=6):
- Reset release with ch0=16'h1234: within 6 scan slots digits 0..3 show 4,3,2,1 (19,30,24,79), digit 4 blank 7F, digit 5 shows 0 (40); digit_en rotates 01,02,04,08,10,20,01 every 4 cycles.
- Pulse next_ch for 3 cycles, then release: ch_sel goes 0->1 exactly once, 3 cycles after the pin rises; digit 5 shows 79. Four more presses: ch_sel wraps 1,2,3,0,1.
- freeze=1, then change ch0 from 16'hABCD to 16'h0000: displayed digits stay D,C,B,A and frozen=1. Step the channel while frozen with ch1=16'h5555: snapshot reloads once to 5555, then holds as ch1 changes to 16'h9999.
- Assert reset mid-scan at prescaler=2, digit 3: seg_out=7F, digit_en=0, ch_sel=0 asynchronously; the scan restarts at digit 0.
- With LEADING_ZERO_BLANK_EN and ch0=16'h0050: digits 3 and 2 blank, digit 1 shows 5 (12), digit 0 shows 0 (40). Without the macro, digits 3 and 2 show 40.
- ch0 changes from 16'h0001 to 16'h0002 while digit 0 is enabled: seg_out changes 79->24 exactly 2 cycles later.
